// File: rtl/cpu_pkg.sv
// Shared constants for the instruction prefetcher: opcode classes and FSM encoding.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned OPC_WIDTH   = 7;

  localparam logic [OPC_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_WIDTH-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_WIDTH-1:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_ISSUE       = 2'd0,
    ST_WAIT_BUS    = 2'd1,
    ST_WAIT_BRANCH = 2'd2
  } fetch_state_e;

  // True for opcodes whose successor PC is unknown until the branch resolves.
  function automatic logic is_ctrl_flow(input logic [OPC_WIDTH-1:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/cpu_prefetch_if.sv
// Bundle of the prefetcher's bus, redirect and consumer signals.
interface cpu_prefetch_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
);

  logic                   bus_request;
  logic                   bus_ready;
  logic [ADDR_WIDTH-1:0]  bus_address;
  logic [INSTR_WIDTH-1:0] bus_rdata;
  logic                   branch;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic                   flush;
  logic [ADDR_WIDTH-1:0]  flush_pc;
  logic                   valid;
  logic                   ready;
  logic [TAG_WIDTH-1:0]   tag;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  pc;

  // Prefetcher side.
  modport master (
    output bus_request, bus_address, valid, tag, instruction, pc,
    input  bus_ready, bus_rdata, branch, pc_next, flush, flush_pc, ready
  );

  // Memory / pipeline side.
  modport slave (
    input  bus_request, bus_address, valid, tag, instruction, pc,
    output bus_ready, bus_rdata, branch, pc_next, flush, flush_pc, ready
  );

endinterface

// File: rtl/cpu_fetch_fifo.sv
// Instruction queue: circular buffer with occupancy count and synchronous clear.
module cpu_fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer/count update; a pop frees the slot a same-cycle push may reuse.
  always_comb begin
    do_pop   = pop && !empty && !clear;
    do_push  = push && !clear && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while count marks them live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_prefetch.sv
// Single-outstanding instruction prefetcher with branch stall and flush redirect.
module cpu_prefetch
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter int unsigned           TAG_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  output logic                   o_bus_request,
  input  logic                   i_bus_ready,
  output logic [ADDR_WIDTH-1:0]  o_bus_address,
  input  logic [INSTR_WIDTH-1:0] i_bus_rdata,
  input  logic                   i_branch,
  input  logic [ADDR_WIDTH-1:0]  i_pc_next,
  input  logic                   i_flush,
  input  logic [ADDR_WIDTH-1:0]  i_flush_pc,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [TAG_WIDTH-1:0]   o_tag,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc
);

  localparam int unsigned ENTRY_W = TAG_WIDTH + INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;

  assign o_valid       = !fifo_empty;
  assign fifo_pop      = o_valid && i_ready;
  assign o_bus_request = req_q;
  assign o_bus_address = addr_q;
  assign {o_tag, o_instruction, o_pc} = fifo_rdata;
  assign fifo_wdata    = {tag_q + TAG_WIDTH'(1), i_bus_rdata, pc_q};

  // Next-state logic: issue, wait for the bus, stall on control flow; flush overrides all.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tag_d     = tag_q;
    req_d     = req_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (i_flush) begin
          pc_d = i_flush_pc;
        end else if (!fifo_full || fifo_pop) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_WAIT_BUS;
        end
      end
      ST_WAIT_BUS: begin
        if (i_bus_ready) begin
          req_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = ST_ISSUE;
          if (i_flush) begin
            pc_d = i_flush_pc;
          end else if (!discard_q) begin
            fifo_push = 1'b1;
            tag_d     = tag_q + TAG_WIDTH'(1);
            pc_d      = pc_q + PC_STEP;
            if (is_ctrl_flow(i_bus_rdata[OPC_WIDTH-1:0])) state_d = ST_WAIT_BRANCH;
          end
        end else if (i_flush) begin
          // Request must stay up until the bus answers; its data is dropped later.
          pc_d      = i_flush_pc;
          discard_d = 1'b1;
        end
      end
      ST_WAIT_BRANCH: begin
        if (i_flush) begin
          pc_d    = i_flush_pc;
          state_d = ST_ISSUE;
        end else if (i_branch) begin
          pc_d    = i_pc_next;
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Control and bus-output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_ISSUE;
      pc_q      <= RESET_PC;
      tag_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

  cpu_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .clear (i_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_cpu_prefetch.sv
// Bench for cpu_prefetch: directed scenarios plus random traffic against a transaction model.
module tb_cpu_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cpu_prefetch_if #(.ADDR_WIDTH(32), .TAG_WIDTH(8)) bus ();
  cpu_prefetch_if #(.ADDR_WIDTH(32), .TAG_WIDTH(2)) b2 ();

  cpu_prefetch #(.ADDR_WIDTH(32), .QUEUE_DEPTH(DEPTH), .TAG_WIDTH(8), .RESET_PC(32'h0)) dut (
    .i_clock(clk), .i_reset(rst),
    .o_bus_request(bus.bus_request), .i_bus_ready(bus.bus_ready),
    .o_bus_address(bus.bus_address), .i_bus_rdata(bus.bus_rdata),
    .i_branch(bus.branch), .i_pc_next(bus.pc_next),
    .i_flush(bus.flush), .i_flush_pc(bus.flush_pc),
    .o_valid(bus.valid), .i_ready(bus.ready),
    .o_tag(bus.tag), .o_instruction(bus.instruction), .o_pc(bus.pc)
  );

  cpu_prefetch #(.ADDR_WIDTH(32), .QUEUE_DEPTH(DEPTH), .TAG_WIDTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_clock(clk), .i_reset(rst),
    .o_bus_request(b2.bus_request), .i_bus_ready(b2.bus_ready),
    .o_bus_address(b2.bus_address), .i_bus_rdata(b2.bus_rdata),
    .i_branch(b2.branch), .i_pc_next(b2.pc_next),
    .i_flush(b2.flush), .i_flush_pc(b2.flush_pc),
    .o_valid(b2.valid), .i_ready(b2.ready),
    .o_tag(b2.tag), .o_instruction(b2.instruction), .o_pc(b2.pc)
  );

  // Wrap instance: zero-wait bus of NOPs, consumer always ready.
  assign b2.bus_ready = b2.bus_request;
  assign b2.bus_rdata = NOP;
  assign b2.branch    = 1'b0;
  assign b2.pc_next   = '0;
  assign b2.flush     = 1'b0;
  assign b2.flush_pc  = '0;
  assign b2.ready     = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  tag;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_pc;
  logic [7:0]  m_tag;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_disc;
  bit          m_wait_br;

  // stimulus knobs
  bit          drv_ready, drv_flush, drv_branch, bus_hold, rand_mem, beq_en;
  logic [31:0] drv_flush_pc, drv_pc_next;
  int          bus_delay, req_age, stall, n_req, n_push;
  logic [31:0] last_req_addr;

  function automatic bit is_cf(input logic [31:0] w);
    logic [6:0] o;
    o = w[6:0];
    return (o == 7'h63) || (o == 7'h6F) || (o == 7'h67);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0:       w[6:0] = 7'h63;
      1:       w[6:0] = 7'h6F;
      2:       w[6:0] = 7'h67;
      default: w[6:0] = 7'h13;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (rand_mem) return rand_word();
    if (beq_en && a == 32'h8) return 32'h0000_0463;
    return NOP;
  endfunction

  // One cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic step();
    exp_t        e;
    logic [31:0] rd;
    bit          br;
    chk("valid", bus.valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("head_tag", bus.tag, mq[0].tag);
      chk("head_instr", bus.instruction, mq[0].instr);
      chk("head_pc", bus.pc, mq[0].pc);
    end
    if (bus.bus_request) begin
      if (!m_out) begin
        chk("req_addr", bus.bus_address, m_pc);
        chk("req_room", (mq.size() < DEPTH) && !m_wait_br, 1'b1);
        m_out         = 1;
        m_addr        = bus.bus_address;
        req_age       = 0;
        n_req++;
        last_req_addr = bus.bus_address;
      end else begin
        chk("req_hold", bus.bus_address, m_addr);
      end
      req_age++;
    end else if (m_out) begin
      chk("req_dropped", bus.bus_request, 1'b1);
      m_out = 0;
    end
    if (!bus.bus_request && !m_wait_br && mq.size() < DEPTH) stall++;
    else stall = 0;
    chk("issue_stall", stall < 2, 1'b1);

    br = m_out && !bus_hold && (req_age >= bus_delay);
    rd = br ? word_at(m_addr) : 32'($urandom);
    bus.ready     = drv_ready;
    bus.bus_ready = br;
    bus.bus_rdata = rd;
    bus.flush     = drv_flush;
    bus.flush_pc  = drv_flush_pc;
    bus.branch    = drv_branch;
    bus.pc_next   = drv_pc_next;

    if (mq.size() != 0 && drv_ready) void'(mq.pop_front());
    if (drv_flush) begin
      mq.delete();
      m_pc      = drv_flush_pc;
      m_wait_br = 0;
      stall     = 0;
      if (m_out) begin
        if (br) begin m_out = 0; m_disc = 0; end
        else m_disc = 1;
      end
    end else if (m_out && br) begin
      m_out = 0;
      if (m_disc) m_disc = 0;
      else begin
        m_tag   = m_tag + 8'd1;
        e.tag   = m_tag;
        e.instr = rd;
        e.pc    = m_addr;
        mq.push_back(e);
        n_push++;
        m_pc = m_addr + 32'd4;
        if (is_cf(rd)) m_wait_br = 1;
      end
    end else if (m_wait_br && drv_branch) begin
      m_pc      = drv_pc_next;
      m_wait_br = 0;
    end
    @(negedge clk);
    drv_flush  = 0;
    drv_branch = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_tag = 8'h0; m_addr = 32'h0;
    m_out = 0; m_disc = 0; m_wait_br = 0;
    stall = 0; req_age = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ready = 0; bus.bus_ready = 0; bus.bus_rdata = '0; bus.flush = 0;
    bus.flush_pc = '0; bus.branch = 0; bus.pc_next = '0;
    drv_ready = 0; drv_flush = 0; drv_branch = 0; bus_hold = 0;
    rand_mem = 0; beq_en = 0; bus_delay = 1;
    drv_flush_pc = '0; drv_pc_next = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_req", bus.bus_request, 1'b0);
    chk("rst_addr", bus.bus_address, 32'h0);
    model_reset();
    rst = 1'b0;
  endtask

  // Wrap instance: tags wrap at 4, PC wraps past 2^32.
  initial begin
    logic [1:0]  et[5];
    logic [31:0] ep[5];
    int k;
    et = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ep = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    k = 0;
    @(negedge rst);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (b2.valid && k < 5) begin
        chk("wrap_tag", b2.tag, et[k]);
        chk("wrap_pc", b2.pc, ep[k]);
        k++;
      end
    end
    chk("wrap_count", k, 5);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=still_running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] tag_before;

    // Streaming NOPs: first request right after reset, one instruction per 2 cycles.
    do_reset();
    drv_ready = 1;
    n_push = 0;
    step();
    chk("first_req", bus.bus_request, 1'b1);
    repeat (19) step();
    chk("nop_rate", n_push, 10);

    // Stalled consumer: exactly DEPTH fetches, then one more per pop.
    do_reset();
    n_req = 0;
    repeat (20) step();
    chk("full_fetches", n_req, 4);
    chk("full_idle", bus.bus_request, 1'b0);
    drv_ready = 1;
    step();
    drv_ready = 0;
    n_req = 0;
    repeat (10) step();
    chk("one_more", n_req, 1);
    chk("one_more_addr", last_req_addr, 32'h10);

    // BEQ at PC 8 stalls fetch until the branch resolves.
    do_reset();
    beq_en = 1;
    drv_ready = 1;
    for (int k = 0; k < 20 && !m_wait_br; k++) step();
    chk("beq_wait", m_wait_br, 1'b1);
    n_req = 0;
    repeat (6) step();
    chk("beq_no_req", n_req, 0);
    drv_branch = 1;
    drv_pc_next = 32'h40;
    drv_ready = 0;
    repeat (3) step();
    chk("beq_req_count", n_req, 1);
    chk("beq_target", last_req_addr, 32'h40);
    step();
    chk("beq_tag", bus.tag, 8'd4);
    chk("beq_pc", bus.pc, 32'h40);

    // Flush while waiting on the bus: data dropped, refetch at the flush PC.
    do_reset();
    repeat (6) step();
    bus_hold = 1;
    for (int k = 0; k < 10 && !m_out; k++) step();
    chk("fl_outstanding", m_out, 1'b1);
    tag_before = m_tag;
    drv_flush = 1;
    drv_flush_pc = 32'h100;
    step();
    chk("fl_valid", bus.valid, 1'b0);
    chk("fl_req_kept", bus.bus_request, 1'b1);
    step();
    step();
    bus_hold = 0;
    step();
    chk("fl_discard_valid", bus.valid, 1'b0);
    n_req = 0;
    step();
    step();
    chk("fl_target", last_req_addr, 32'h100);
    chk("fl_req_count", n_req, 1);
    step();
    chk("fl_tag", bus.tag, tag_before + 8'd1);

    // Asynchronous reset in the middle of a bus wait.
    do_reset();
    drv_ready = 1;
    repeat (6) step();
    bus_hold = 1;
    for (int k = 0; k < 10 && !m_out; k++) step();
    chk("ar_req_before", bus.bus_request, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_drop", bus.bus_request, 1'b0);
    chk("ar_valid", bus.valid, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    bus_hold = 0;
    @(negedge clk);
    chk("ar_req_after", bus.bus_request, 1'b1);
    chk("ar_addr_after", bus.bus_address, 32'h0);
    repeat (6) step();

    // Random traffic: ready, bus latency, flushes, branches (also stray ones).
    do_reset();
    rand_mem = 1;
    for (int i = 0; i < 3000; i++) begin
      drv_ready    = ($urandom_range(0, 9) < 7);
      bus_delay    = $urandom_range(1, 3);
      drv_flush    = ($urandom_range(0, 39) == 0);
      drv_flush_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drv_branch   = m_wait_br ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      drv_pc_next  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
